// File: rtl/reg_addr_pipe_if.sv
// Bundles the D-stage inputs, the query address and the per-stage tracking outputs of
// the register-address pipeline. Master drives D-stage/control, slave is the pipeline.
interface reg_addr_pipe_if #(
    parameter int CHANNELS = 2,
    parameter int ADDR_W   = 5,
    parameter int DEPTH    = 3
);
    logic                               stall_i;
    logic                               flush_i;
    logic [CHANNELS*ADDR_W-1:0]         addr_d_i;
    logic [CHANNELS-1:0]                valid_d_i;
    logic [ADDR_W-1:0]                  cmp_addr_i;
    logic [DEPTH*CHANNELS*ADDR_W-1:0]   stage_addr_o;
    logic [DEPTH*CHANNELS-1:0]          stage_vld_o;
    logic [DEPTH*CHANNELS-1:0]          hit_o;
    logic [DEPTH-1:0]                   occupied_o;

    modport master (
        output stall_i, flush_i, addr_d_i, valid_d_i, cmp_addr_i,
        input  stage_addr_o, stage_vld_o, hit_o, occupied_o
    );

    modport slave (
        input  stall_i, flush_i, addr_d_i, valid_d_i, cmp_addr_i,
        output stage_addr_o, stage_vld_o, hit_o, occupied_o
    );
endinterface

// File: rtl/reg_addr_pipe.sv
// Tracks per-instruction operand register addresses through DEPTH stages after D,
// with bubble-on-stall, front-of-pipe flush and per-stage query-address compare.
module reg_addr_pipe #(
    parameter int CHANNELS     = 2,
    parameter int ADDR_W       = 5,
    parameter int DEPTH        = 3,
    parameter int FLUSH_DEPTH  = 1,
    parameter int ZERO_IS_NULL = 1
) (
    input  logic           clk,
    input  logic           reset,
    reg_addr_pipe_if.slave bus
);
    localparam int SW     = CHANNELS * ADDR_W;
    localparam int AW_ALL = DEPTH * SW;
    localparam int VW_ALL = DEPTH * CHANNELS;

    logic [AW_ALL-1:0] addr_q;
    logic [AW_ALL-1:0] addr_d;
    logic [AW_ALL-1:0] src_addr;
    logic [VW_ALL-1:0] vld_q;
    logic [VW_ALL-1:0] vld_d;
    logic [VW_ALL-1:0] src_vld;
    logic [DEPTH-1:0]  kill;
    logic              cmp_live;

    // A zero query never matches when register 0 is the hard-wired null register.
    assign cmp_live = (ZERO_IS_NULL == 0) || (bus.cmp_addr_i != '0);

    genvar gi, gc;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_stage
            localparam bit FLUSHABLE = (gi < FLUSH_DEPTH);

            if (gi == 0) begin : g_head
                assign src_addr[0 +: SW]       = bus.addr_d_i;
                assign src_vld[0 +: CHANNELS]  = bus.valid_d_i;
                assign kill[0]                 = bus.stall_i | (bus.flush_i & FLUSHABLE);
            end else begin : g_body
                assign src_addr[gi*SW +: SW]            = addr_q[(gi-1)*SW +: SW];
                assign src_vld[gi*CHANNELS +: CHANNELS] = vld_q[(gi-1)*CHANNELS +: CHANNELS];
                assign kill[gi]                         = bus.flush_i & FLUSHABLE;
            end

            for (gc = 0; gc < CHANNELS; gc++) begin : g_ch
                localparam int IDX = gi * CHANNELS + gc;
                assign bus.hit_o[IDX] = vld_q[IDX] & cmp_live &
                                        (addr_q[IDX*ADDR_W +: ADDR_W] == bus.cmp_addr_i);
            end

            assign bus.occupied_o[gi] = |vld_q[gi*CHANNELS +: CHANNELS];
        end
    endgenerate

    always_comb begin
        addr_d = src_addr;
        vld_d  = src_vld;
        for (int s = 0; s < DEPTH; s++) begin
            if (kill[s]) begin
                addr_d[s*SW +: SW]            = '0;
                vld_d[s*CHANNELS +: CHANNELS] = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q <= '0;
            vld_q  <= '0;
        end else begin
            addr_q <= addr_d;
            vld_q  <= vld_d;
        end
    end

    assign bus.stage_addr_o = addr_q;
    assign bus.stage_vld_o  = vld_q;

endmodule

// File: tb/tb_reg_addr_pipe.sv
// Directed and random checks of reg_addr_pipe with FLUSH_DEPTH 1 and 2 side by side,
// against a history-array model of what each stage should hold.
module tb_reg_addr_pipe;
    localparam int CH = 2;
    localparam int AW = 5;
    localparam int DP = 3;
    localparam int SW = CH * AW;

    typedef struct packed {
        logic [SW-1:0] addr;
        logic [CH-1:0] vld;
    } ent_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          stall;
    logic          flush;
    logic [SW-1:0] addr_in;
    logic [CH-1:0] vld_in;
    logic [AW-1:0] cmp;

    ent_t pipe_m [2][DP];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_fail   = 0;

    reg_addr_pipe_if #(.CHANNELS(CH), .ADDR_W(AW), .DEPTH(DP)) if_a ();
    reg_addr_pipe_if #(.CHANNELS(CH), .ADDR_W(AW), .DEPTH(DP)) if_b ();

    reg_addr_pipe #(.CHANNELS(CH), .ADDR_W(AW), .DEPTH(DP), .FLUSH_DEPTH(1), .ZERO_IS_NULL(1))
        dut_a (.clk(clk), .reset(rst_n), .bus(if_a.slave));
    reg_addr_pipe #(.CHANNELS(CH), .ADDR_W(AW), .DEPTH(DP), .FLUSH_DEPTH(2), .ZERO_IS_NULL(1))
        dut_b (.clk(clk), .reset(rst_n), .bus(if_b.slave));

    assign if_a.stall_i    = stall;
    assign if_a.flush_i    = flush;
    assign if_a.addr_d_i   = addr_in;
    assign if_a.valid_d_i  = vld_in;
    assign if_a.cmp_addr_i = cmp;
    assign if_b.stall_i    = stall;
    assign if_b.flush_i    = flush;
    assign if_b.addr_d_i   = addr_in;
    assign if_b.valid_d_i  = vld_in;
    assign if_b.cmp_addr_i = cmp;

    always #5 clk = ~clk;

    task automatic model_reset();
        for (int k = 0; k < 2; k++)
            for (int s = 0; s < DP; s++)
                pipe_m[k][s] = '0;
    endtask

    // Each edge: history moves one stage on, the newest entry is a bubble on stall/flush,
    // and flush wipes the first fd stages of the resulting history.
    task automatic model_edge(int k, int fd);
        for (int s = DP - 1; s > 0; s--) pipe_m[k][s] = pipe_m[k][s-1];
        pipe_m[k][0] = (stall || flush) ? ent_t'('0) : {addr_in, vld_in};
        if (flush)
            for (int s = 0; s < fd; s++) pipe_m[k][s] = '0;
    endtask

    function automatic logic [DP*SW-1:0] exp_addr(int k);
        logic [DP*SW-1:0] r = '0;
        for (int s = 0; s < DP; s++) r[s*SW +: SW] = pipe_m[k][s].addr;
        return r;
    endfunction

    function automatic logic [DP*CH-1:0] exp_vld(int k);
        logic [DP*CH-1:0] r = '0;
        for (int s = 0; s < DP; s++) r[s*CH +: CH] = pipe_m[k][s].vld;
        return r;
    endfunction

    function automatic logic [DP*CH-1:0] exp_hit(int k);
        logic [DP*CH-1:0] r = '0;
        logic [AW-1:0]    a;
        for (int s = 0; s < DP; s++)
            for (int c = 0; c < CH; c++) begin
                a = pipe_m[k][s].addr[c*AW +: AW];
                r[s*CH+c] = pipe_m[k][s].vld[c] && (a == cmp) && (cmp != 0);
            end
        return r;
    endfunction

    function automatic logic [DP-1:0] exp_occ(int k);
        logic [DP-1:0] r = '0;
        for (int s = 0; s < DP; s++) r[s] = |pipe_m[k][s].vld;
        return r;
    endfunction

    task automatic check(string tag, logic [63:0] obs, logic [63:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic check_all(string tag);
        check({tag, " a.addr"}, 64'(if_a.stage_addr_o), 64'(exp_addr(0)));
        check({tag, " a.vld"},  64'(if_a.stage_vld_o),  64'(exp_vld(0)));
        check({tag, " a.hit"},  64'(if_a.hit_o),        64'(exp_hit(0)));
        check({tag, " a.occ"},  64'(if_a.occupied_o),   64'(exp_occ(0)));
        check({tag, " b.addr"}, 64'(if_b.stage_addr_o), 64'(exp_addr(1)));
        check({tag, " b.vld"},  64'(if_b.stage_vld_o),  64'(exp_vld(1)));
        check({tag, " b.hit"},  64'(if_b.hit_o),        64'(exp_hit(1)));
        check({tag, " b.occ"},  64'(if_b.occupied_o),   64'(exp_occ(1)));
    endtask

    task automatic step(string tag);
        @(posedge clk);
        model_edge(0, 1);
        model_edge(1, 2);
        #1;
        $display("%-10s st=%0b fl=%0b d=%h v=%b cmp=%0d | a.addr=%h a.vld=%b a.hit=%b | b.addr=%h b.vld=%b",
                 tag, stall, flush, addr_in, vld_in, cmp,
                 if_a.stage_addr_o, if_a.stage_vld_o, if_a.hit_o,
                 if_b.stage_addr_o, if_b.stage_vld_o);
        check_all(tag);
    endtask

    task automatic drive(logic st, logic fl, logic [SW-1:0] a, logic [CH-1:0] v, logic [AW-1:0] q);
        stall   = st;
        flush   = fl;
        addr_in = a;
        vld_in  = v;
        cmp     = q;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(0, 0, '0, '0, '0);
        model_reset();
        #22;
        check_all("reset");
        rst_n = 1'b1;

        // idle after reset release
        for (int i = 0; i < 5; i++) step("idle");

        // (ch1=3, ch0=7) walks through, query 7 lights hit bits 0, 2, 4
        drive(0, 0, {5'd3, 5'd7}, 2'b11, 5'd7);
        step("walk");
        check("walk hit e1", 64'(if_a.hit_o), 64'd1);
        vld_in = 2'b00;
        for (int i = 1; i < 4; i++) begin
            step("walk");
            check("walk hit", 64'(if_a.hit_o), (i < 3) ? (64'd1 << (2 * i)) : 64'd0);
        end

        // address 0 valid with query 0 never hits
        drive(0, 0, '0, 2'b11, 5'd0);
        for (int i = 0; i < 3; i++) step("zero");
        check("zero hit", 64'(if_a.hit_o), 64'd0);

        // stream 1,2,3 on ch0 with a stall while 2 is presented
        drive(0, 0, {5'd0, 5'd1}, 2'b01, 5'd2);
        step("stream");
        drive(1, 0, {5'd0, 5'd2}, 2'b01, 5'd2);
        step("stall");
        check("stall bubble", 64'(if_a.stage_vld_o[1:0]), 64'd0);
        drive(0, 0, {5'd0, 5'd2}, 2'b01, 5'd2);
        step("stream");
        drive(0, 0, {5'd0, 5'd3}, 2'b01, 5'd2);
        for (int i = 0; i < 4; i++) step("stream");

        // flush together with stall while stage 0 holds 9
        drive(0, 0, {5'd0, 5'd9}, 2'b01, 5'd9);
        step("load9");
        drive(1, 1, {5'd0, 5'd4}, 2'b01, 5'd9);
        step("flush");
        check("flush a s1", 64'(if_a.stage_addr_o[SW +: AW]), 64'd9);
        check("flush b s1", 64'(if_b.stage_vld_o[CH +: CH]), 64'd0);
        drive(0, 0, '0, '0, 5'd9);
        for (int i = 0; i < 3; i++) step("drain");

        // random traffic on a small address range so hits are frequent
        for (int i = 0; i < 300; i++) begin
            drive($urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0,
                  {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))},
                  2'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
            step("rand");
        end

        // fill every stage, then pulse reset between edges
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, {5'($urandom_range(1, 31)), 5'($urandom_range(1, 31))}, 2'b11, 5'd1);
            step("fill");
        end
        check("full occ", 64'(if_a.occupied_o), 64'd7);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("rst_pulse");
        #1;
        rst_n = 1'b1;
        drive(0, 0, {5'd6, 5'd5}, 2'b10, 5'd6);
        for (int i = 0; i < 4; i++) step("post");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
